// File: rtl/hpi_pkg.sv
// hpi_pkg
// Shared definitions for the HPI target model:
//   - host register select codes driven on hpi_address
//   - bit positions inside the STATUS register
//   - state encoding for the host access sequencer
package hpi_pkg;

  // Host register select codes (hpi_address)
  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // STATUS register bit positions
  localparam int ST_TXF = 0;  // device->host mailbox full
  localparam int ST_RXV = 1;  // host->device mailbox word pending
  localparam int ST_OVR = 2;  // host overwrote an unconsumed mailbox word

  // Host access sequencer states
  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD2,
    HOLD
  } hpi_state_t;

endpackage

// File: rtl/hpi_responder_dpram.sv
// hpi_responder_dpram
// True dual-port 16-bit word RAM backing the HPI DATA window.
// Port A belongs to the host sequencer, port B to FPGA fabric.
// Both ports are read-first: rdata shows the contents from before a write
// landing on the same edge. When both ports write one word on the same
// edge, port A (host) wins.
// Ports:
//   clk, rst          clock, async active-high reset (read registers only)
//   a_addr/a_wdata/a_we/a_rdata   host port
//   b_addr/b_wdata/b_we/b_rdata   fabric port
module hpi_responder_dpram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_wdata,
  input  logic              a_we,
  output logic [15:0]       a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [15:0]       b_wdata,
  input  logic              b_we,
  output logic [15:0]       b_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [15:0] mem [DEPTH];

  // Storage has no reset, so it stays out of the reset domain. The fabric
  // write is suppressed when the host writes the same word this edge.
  always_ff @(posedge clk) begin
    if (b_we && !(a_we && (a_addr == b_addr))) begin
      mem[b_addr] <= b_wdata;
    end
    if (a_we) begin
      mem[a_addr] <= a_wdata;
    end
  end

  // Read registers sample the pre-write contents (read-first) and clear on
  // reset so both read ports come up as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata <= 16'h0000;
      b_rdata <= 16'h0000;
    end else begin
      a_rdata <= mem[a_addr];
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/hpi_responder.sv
// hpi_responder
// Target-side model of a 16-bit CY7C67200-style Host Port Interface.
// Answers host accesses to DATA / MAILBOX / ADDRESS / STATUS, backs DATA
// with an on-chip word RAM, and exposes a fabric RAM port plus two
// valid/ready mailboxes.
// Ports:
//   Clk, Reset                 clock, async active-high reset
//   hpi_address, hpi_data_in   host register select and write data
//   hpi_data_out               last value read by the host
//   hpi_cs_n/r_n/w_n           host chip select and strobes (active low)
//   hpi_reset_n                host soft reset (active low, synchronous)
//   hpi_int                    high while device->host mailbox is full
//   mbx_rx_*                   host->device mailbox toward fabric
//   mbx_tx_*                   device->host mailbox from fabric
//   loc_*                      fabric RAM port, 1-cycle read latency
module hpi_responder
  import hpi_pkg::*;
#(
  parameter int          ADDR_W  = 12,
  parameter logic [15:0] RST_MBX = 16'h0000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        hpi_address,
  input  logic [15:0]       hpi_data_in,
  output logic [15:0]       hpi_data_out,
  input  logic              hpi_cs_n,
  input  logic              hpi_r_n,
  input  logic              hpi_w_n,
  input  logic              hpi_reset_n,
  output logic              hpi_int,
  output logic [15:0]       mbx_rx_data,
  output logic              mbx_rx_valid,
  input  logic              mbx_rx_ack,
  input  logic [15:0]       mbx_tx_data,
  input  logic              mbx_tx_valid,
  output logic              mbx_tx_ready,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [15:0]       loc_wdata,
  input  logic              loc_we,
  output logic [15:0]       loc_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Registered copies of the host pins
  logic [1:0]  addr_s;
  logic [15:0] data_s;
  logic        cs_s, r_s, w_s, hrst_s;

  hpi_state_t  state_q, state_d;

  logic [15:0] addr_reg;
  logic [15:0] tx_data_q;
  logic        tx_full_q;
  logic        ovr_q;

  logic [14:0] word_idx;
  logic        in_range;
  logic        do_wr, do_rd;
  logic        ram_we;
  logic [15:0] ram_q;
  logic [15:0] status_word;

  // All host pins go through one register stage before any decode. Strobes
  // and soft reset come up in their inactive levels.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_s <= 2'd0;
      data_s <= 16'h0000;
      cs_s   <= 1'b1;
      r_s    <= 1'b1;
      w_s    <= 1'b1;
      hrst_s <= 1'b1;
    end else begin
      addr_s <= hpi_address;
      data_s <= hpi_data_in;
      cs_s   <= hpi_cs_n;
      r_s    <= hpi_r_n;
      w_s    <= hpi_w_n;
      hrst_s <= hpi_reset_n;
    end
  end

  // addr_reg is a byte address; bit 0 is ignored for RAM indexing. Word
  // indices past the RAM end drop writes and read back as zero.
  assign word_idx    = addr_reg[15:1];
  assign in_range    = (32'(word_idx) < DEPTH);
  assign do_wr       = (state_q == WR)  && hrst_s;
  assign do_rd       = (state_q == RD2) && hrst_s;
  assign ram_we      = do_wr && (addr_s == HPI_DATA) && in_range;
  assign status_word = {13'd0, ovr_q, mbx_rx_valid, tx_full_q};

  // Sequencer state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one access per strobe assertion. Both strobes low at once
  // is treated as nonsense and ignored. HOLD waits for the strobe to go away
  // so a long strobe never repeats the access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!cs_s && !w_s && r_s) begin
          state_d = WR;
        end else if (!cs_s && !r_s && w_s) begin
          state_d = RD;
        end
      end
      WR:   state_d = HOLD;
      RD:   state_d = RD2;
      RD2:  state_d = HOLD;
      HOLD: begin
        if (cs_s || (r_s && w_s)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!hrst_s) begin
      state_d = IDLE;
    end
  end

  // Address register: loaded by ADDRESS writes, post-incremented by two on
  // every DATA access, wrapping naturally at 16 bits.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_reg <= 16'h0000;
    end else if (!hrst_s) begin
      addr_reg <= 16'h0000;
    end else if (do_wr && (addr_s == HPI_ADDRESS)) begin
      addr_reg <= data_s;
    end else if ((do_wr || do_rd) && (addr_s == HPI_DATA)) begin
      addr_reg <= addr_reg + 16'd2;
    end
  end

  // Read data returned to the host; it holds between reads and survives
  // the host soft reset. ram_q was sampled while in RD.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hpi_data_out <= 16'h0000;
    end else if (do_rd) begin
      case (addr_s)
        HPI_DATA:    hpi_data_out <= in_range ? ram_q : 16'h0000;
        HPI_MAILBOX: hpi_data_out <= tx_data_q;
        HPI_ADDRESS: hpi_data_out <= addr_reg;
        default:     hpi_data_out <= status_word;
      endcase
    end
  end

  // Host->device mailbox. A host write beats a same-cycle ack; writing
  // over a still-pending word raises the overrun flag, which the host
  // clears by writing 1 to STATUS bit 2.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mbx_rx_data  <= RST_MBX;
      mbx_rx_valid <= 1'b0;
      ovr_q        <= 1'b0;
    end else if (!hrst_s) begin
      mbx_rx_data  <= RST_MBX;
      mbx_rx_valid <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      if (do_wr && (addr_s == HPI_MAILBOX)) begin
        mbx_rx_data  <= data_s;
        mbx_rx_valid <= 1'b1;
        if (mbx_rx_valid) begin
          ovr_q <= 1'b1;
        end
      end else if (mbx_rx_ack) begin
        mbx_rx_valid <= 1'b0;
      end
      if (do_wr && (addr_s == HPI_STATUS) && data_s[ST_OVR]) begin
        ovr_q <= 1'b0;
      end
    end
  end

  // Device->host mailbox. Fabric loads on valid & ready; a host MAILBOX
  // read empties it. Loading is impossible while full, so the two never
  // collide.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tx_data_q <= RST_MBX;
      tx_full_q <= 1'b0;
    end else if (!hrst_s) begin
      tx_data_q <= RST_MBX;
      tx_full_q <= 1'b0;
    end else if (do_rd && (addr_s == HPI_MAILBOX)) begin
      tx_full_q <= 1'b0;
    end else if (mbx_tx_valid && !tx_full_q) begin
      tx_data_q <= mbx_tx_data;
      tx_full_q <= 1'b1;
    end
  end

  assign hpi_int      = tx_full_q;
  assign mbx_tx_ready = ~tx_full_q;

  hpi_responder_dpram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (Clk),
    .rst     (Reset),
    .a_addr  (word_idx[ADDR_W-1:0]),
    .a_wdata (data_s),
    .a_we    (ram_we),
    .a_rdata (ram_q),
    .b_addr  (loc_addr),
    .b_wdata (loc_wdata),
    .b_we    (loc_we),
    .b_rdata (loc_rdata)
  );

endmodule

// File: tb/tb_hpi_responder.sv
// tb_hpi_responder
// Directed bench for hpi_responder: a table of host accesses with
// hand-computed read results, followed by hand-written sequences for the
// mailbox handshakes, fabric RAM port, address wrap, long/illegal strobes,
// host soft reset and async reset.
module tb_hpi_responder;
  import hpi_pkg::*;

  localparam int ADDR_W = 12;

  logic              Clk;
  logic              Reset;
  logic [1:0]        hpi_address;
  logic [15:0]       hpi_data_in;
  logic [15:0]       hpi_data_out;
  logic              hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n;
  logic              hpi_int;
  logic [15:0]       mbx_rx_data;
  logic              mbx_rx_valid;
  logic              mbx_rx_ack;
  logic [15:0]       mbx_tx_data;
  logic              mbx_tx_valid;
  logic              mbx_tx_ready;
  logic [ADDR_W-1:0] loc_addr;
  logic [15:0]       loc_wdata;
  logic              loc_we;
  logic [15:0]       loc_rdata;

  int checks   = 0;
  int failures = 0;

  hpi_responder #(
    .ADDR_W  (ADDR_W),
    .RST_MBX (16'h0000)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .hpi_address  (hpi_address),
    .hpi_data_in  (hpi_data_in),
    .hpi_data_out (hpi_data_out),
    .hpi_cs_n     (hpi_cs_n),
    .hpi_r_n      (hpi_r_n),
    .hpi_w_n      (hpi_w_n),
    .hpi_reset_n  (hpi_reset_n),
    .hpi_int      (hpi_int),
    .mbx_rx_data  (mbx_rx_data),
    .mbx_rx_valid (mbx_rx_valid),
    .mbx_rx_ack   (mbx_rx_ack),
    .mbx_tx_data  (mbx_tx_data),
    .mbx_tx_valid (mbx_tx_valid),
    .mbx_tx_ready (mbx_tx_ready),
    .loc_addr     (loc_addr),
    .loc_wdata    (loc_wdata),
    .loc_we       (loc_we),
    .loc_rdata    (loc_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        is_read;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [13];

  // Compare one observed value with its expected value
  task automatic checkOutput(input string name, input logic [15:0] got,
                             input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One host access: strobe held for 'hold' cycles, then released and the
  // sequencer given time to return to IDLE before hpi_data_out is sampled.
  task automatic hostAccess(input logic is_read, input logic [1:0] a,
                            input logic [15:0] d, input int hold,
                            output logic [15:0] rd);
    @(negedge Clk);
    hpi_address = a;
    hpi_data_in = d;
    hpi_cs_n    = 1'b0;
    if (is_read) hpi_r_n = 1'b0;
    else         hpi_w_n = 1'b0;
    repeat (hold) @(negedge Clk);
    hpi_cs_n = 1'b1;
    hpi_r_n  = 1'b1;
    hpi_w_n  = 1'b1;
    repeat (3) @(negedge Clk);
    rd = hpi_data_out;
  endtask

  task automatic applyStimulus(input vec_t v, output logic [15:0] rd);
    hostAccess(v.is_read, v.addr, v.wdata, 5, rd);
  endtask

  task automatic hostWrite(input logic [1:0] a, input logic [15:0] d);
    logic [15:0] dummy;
    hostAccess(1'b0, a, d, 5, dummy);
  endtask

  task automatic hostRead(input logic [1:0] a, output logic [15:0] rd);
    hostAccess(1'b1, a, 16'h0000, 5, rd);
  endtask

  // Offer one word to the device->host mailbox for a single cycle
  task automatic fabricTx(input logic [15:0] d);
    @(negedge Clk);
    mbx_tx_data  = d;
    mbx_tx_valid = 1'b1;
    @(negedge Clk);
    mbx_tx_valid = 1'b0;
  endtask

  function automatic vec_t mkVec(input logic is_read, input logic [1:0] a,
                                 input logic [15:0] d, input logic [15:0] e);
    vec_t v;
    v.is_read = is_read;
    v.addr    = a;
    v.wdata   = d;
    v.exp     = e;
    return v;
  endfunction

  initial begin
    logic [15:0] rd;

    // Table: RAM burst via auto-increment, then rx mailbox overrun/status
    vecs[0]  = mkVec(1'b0, HPI_ADDRESS, 16'h0100, 16'h0000);
    vecs[1]  = mkVec(1'b0, HPI_DATA,    16'hBEEF, 16'h0000);
    vecs[2]  = mkVec(1'b0, HPI_DATA,    16'hCAFE, 16'h0000);
    vecs[3]  = mkVec(1'b0, HPI_ADDRESS, 16'h0100, 16'h0000);
    vecs[4]  = mkVec(1'b1, HPI_DATA,    16'h0000, 16'hBEEF);
    vecs[5]  = mkVec(1'b1, HPI_DATA,    16'h0000, 16'hCAFE);
    vecs[6]  = mkVec(1'b1, HPI_ADDRESS, 16'h0000, 16'h0104);
    vecs[7]  = mkVec(1'b1, HPI_STATUS,  16'h0000, 16'h0000);
    vecs[8]  = mkVec(1'b0, HPI_MAILBOX, 16'hAAAA, 16'h0000);
    vecs[9]  = mkVec(1'b0, HPI_MAILBOX, 16'h5555, 16'h0000);
    vecs[10] = mkVec(1'b1, HPI_STATUS,  16'h0000, 16'h0006);
    vecs[11] = mkVec(1'b0, HPI_STATUS,  16'h0004, 16'h0000);
    vecs[12] = mkVec(1'b1, HPI_STATUS,  16'h0000, 16'h0002);

    Reset        = 1'b1;
    hpi_address  = 2'd0;
    hpi_data_in  = 16'h0000;
    hpi_cs_n     = 1'b1;
    hpi_r_n      = 1'b1;
    hpi_w_n      = 1'b1;
    hpi_reset_n  = 1'b1;
    mbx_rx_ack   = 1'b0;
    mbx_tx_data  = 16'h0000;
    mbx_tx_valid = 1'b0;
    loc_addr     = '0;
    loc_wdata    = 16'h0000;
    loc_we       = 1'b0;

    // Reset state
    repeat (3) @(negedge Clk);
    checkOutput("rst_data_out", hpi_data_out, 16'h0000);
    checkOutput("rst_int", {15'd0, hpi_int}, 16'h0000);
    checkOutput("rst_rx_valid", {15'd0, mbx_rx_valid}, 16'h0000);
    checkOutput("rst_rx_data", mbx_rx_data, 16'h0000);
    checkOutput("rst_tx_ready", {15'd0, mbx_tx_ready}, 16'h0001);
    checkOutput("rst_loc_rdata", loc_rdata, 16'h0000);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], rd);
      if (vecs[i].is_read) checkOutput($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // rx mailbox contents after the double write, then fabric ack
    checkOutput("rx_data_last", mbx_rx_data, 16'h5555);
    checkOutput("rx_valid_set", {15'd0, mbx_rx_valid}, 16'h0001);
    @(negedge Clk);
    mbx_rx_ack = 1'b1;
    @(negedge Clk);
    mbx_rx_ack = 1'b0;
    checkOutput("rx_valid_ack", {15'd0, mbx_rx_valid}, 16'h0000);
    hostRead(HPI_STATUS, rd);
    checkOutput("status_after_ack", rd, 16'h0000);

    // tx mailbox: fabric offers a word, host reads it out
    fabricTx(16'h1234);
    checkOutput("tx_int_set", {15'd0, hpi_int}, 16'h0001);
    checkOutput("tx_ready_low", {15'd0, mbx_tx_ready}, 16'h0000);
    hostRead(HPI_STATUS, rd);
    checkOutput("status_txf", rd, 16'h0001);
    hostRead(HPI_MAILBOX, rd);
    checkOutput("tx_mbx_read", rd, 16'h1234);
    checkOutput("tx_int_clear", {15'd0, hpi_int}, 16'h0000);
    checkOutput("tx_ready_high", {15'd0, mbx_tx_ready}, 16'h0001);

    // Fabric port write, host readback, and fabric read-first behaviour
    @(negedge Clk);
    loc_addr  = 12'h080;
    loc_wdata = 16'h00A5;
    loc_we    = 1'b1;
    @(negedge Clk);
    loc_we = 1'b0;
    @(negedge Clk);
    checkOutput("loc_read", loc_rdata, 16'h00A5);
    hostWrite(HPI_ADDRESS, 16'h0100);
    hostRead(HPI_DATA, rd);
    checkOutput("host_sees_loc", rd, 16'h00A5);
    @(negedge Clk);
    loc_addr  = 12'h081;
    loc_wdata = 16'h1111;
    loc_we    = 1'b1;
    @(negedge Clk);
    loc_we = 1'b0;
    checkOutput("loc_read_first", loc_rdata, 16'hCAFE);
    @(negedge Clk);
    checkOutput("loc_after_write", loc_rdata, 16'h1111);

    // Out-of-range word reads as zero; increment wraps to 0
    hostWrite(HPI_ADDRESS, 16'hFFFE);
    hostRead(HPI_DATA, rd);
    checkOutput("oob_read", rd, 16'h0000);
    hostRead(HPI_ADDRESS, rd);
    checkOutput("addr_wrap", rd, 16'h0000);

    // Long strobe: exactly one post-increment
    hostWrite(HPI_ADDRESS, 16'h0200);
    hostAccess(1'b1, HPI_DATA, 16'h0000, 20, rd);
    hostRead(HPI_ADDRESS, rd);
    checkOutput("long_strobe_once", rd, 16'h0202);

    // Both strobes low: ignored
    hostWrite(HPI_ADDRESS, 16'h0300);
    @(negedge Clk);
    hpi_address = HPI_ADDRESS;
    hpi_data_in = 16'h1234;
    hpi_cs_n = 1'b0;
    hpi_r_n  = 1'b0;
    hpi_w_n  = 1'b0;
    repeat (6) @(negedge Clk);
    hpi_cs_n = 1'b1;
    hpi_r_n  = 1'b1;
    hpi_w_n  = 1'b1;
    repeat (3) @(negedge Clk);
    hostRead(HPI_ADDRESS, rd);
    checkOutput("both_strobes_ignored", rd, 16'h0300);

    // Host soft reset in the middle of a read
    hostWrite(HPI_ADDRESS, 16'h0100);
    hostWrite(HPI_MAILBOX, 16'h7777);
    fabricTx(16'h4321);
    @(negedge Clk);
    hpi_address = HPI_DATA;
    hpi_cs_n = 1'b0;
    hpi_r_n  = 1'b0;
    repeat (2) @(negedge Clk);
    hpi_reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    hpi_cs_n = 1'b1;
    hpi_r_n  = 1'b1;
    @(negedge Clk);
    hpi_reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    checkOutput("srst_rx_valid", {15'd0, mbx_rx_valid}, 16'h0000);
    checkOutput("srst_rx_data", mbx_rx_data, 16'h0000);
    checkOutput("srst_int", {15'd0, hpi_int}, 16'h0000);
    checkOutput("srst_tx_ready", {15'd0, mbx_tx_ready}, 16'h0001);
    hostRead(HPI_ADDRESS, rd);
    checkOutput("srst_addr", rd, 16'h0000);
    hostRead(HPI_STATUS, rd);
    checkOutput("srst_status", rd, 16'h0000);
    hostWrite(HPI_ADDRESS, 16'h0100);
    hostRead(HPI_DATA, rd);
    checkOutput("srst_ram_kept", rd, 16'h00A5);

    // Async reset in the middle of a read: outputs clear immediately
    hostWrite(HPI_MAILBOX, 16'h9999);
    fabricTx(16'h0F0F);
    @(negedge Clk);
    hpi_address = HPI_DATA;
    hpi_cs_n = 1'b0;
    hpi_r_n  = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    checkOutput("arst_data_out", hpi_data_out, 16'h0000);
    checkOutput("arst_int", {15'd0, hpi_int}, 16'h0000);
    checkOutput("arst_tx_ready", {15'd0, mbx_tx_ready}, 16'h0001);
    checkOutput("arst_rx_valid", {15'd0, mbx_rx_valid}, 16'h0000);
    checkOutput("arst_rx_data", mbx_rx_data, 16'h0000);
    checkOutput("arst_loc_rdata", loc_rdata, 16'h0000);
    @(negedge Clk);
    hpi_cs_n = 1'b1;
    hpi_r_n  = 1'b1;
    Reset    = 1'b0;
    repeat (3) @(negedge Clk);
    hostRead(HPI_ADDRESS, rd);
    checkOutput("arst_addr", rd, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hpi_responder.md
Name: hpi_responder

Overview:
Target-side model of the 16-bit CY7C67200-style Host Port Interface (HPI). It answers the accesses that the SoC's otg_hpi PIO bus issues (address/data/mailbox/status registers) and backs them with an on-chip word RAM, so USB/keycode software can run against a simulation or test build without the OTG chip. It also gives FPGA fabric a local RAM port and bidirectional mailboxes with valid/ready handshakes.

Parameters:
ADDR_W, 12, word-address width of backing RAM (DEPTH = 2**ADDR_W words = 8 KB default)
RST_MBX, 16'h0000, reset value of both mailbox data registers

Ports:
Clk  in  1  system clock; all logic rising-edge
Reset  in  1  asynchronous, active-high reset
hpi_address  in  2  0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS
hpi_data_in  in  16  host write data
hpi_data_out  out  16  read data returned to host
hpi_cs_n  in  1  chip select, active low
hpi_r_n  in  1  read strobe, active low
hpi_w_n  in  1  write strobe, active low
hpi_reset_n  in  1  host-driven soft reset, active low
hpi_int  out  1  high while device->host mailbox full
mbx_rx_data  out  16  last host-written mailbox word
mbx_rx_valid  out  1  host mailbox word pending
mbx_rx_ack  in  1  fabric consumes mbx_rx_data
mbx_tx_data  in  16  device->host mailbox word
mbx_tx_valid  in  1  fabric offers mbx_tx_data
mbx_tx_ready  out  1  tx mailbox empty
loc_addr  in  ADDR_W  fabric RAM word address
loc_wdata  in  16  fabric write data
loc_we  in  1  fabric write enable
loc_rdata  out  16  fabric read data, 1-cycle latency

Behaviour:
- Reset: all outputs 0 (mbx_rx_data = RST_MBX), mbx_tx_ready = 1, addr_reg = 0, state IDLE, status clear; RAM contents undefined.
- hpi_reset_n low (sampled): synchronous clear of addr_reg, both mailboxes, status flags, FSM -> IDLE; RAM retained; host accesses ignored while low.
- All HPI inputs registered once (s1) before decode.
- FSM IDLE: cs_n=0, w_n=0, r_n=1 -> WR; cs_n=0, r_n=0, w_n=1 -> RD; both strobes low -> stay IDLE (access ignored).
- WR (1 cycle): DATA: RAM[addr_reg[ADDR_W:1]] <= data, addr_reg += 2; MAILBOX: rx_data <= data, rx_valid <= 1, if rx_valid already set then overrun flag <= 1; ADDRESS: addr_reg <= data; STATUS: data bit2 = 1 clears overrun. -> HOLD.
- RD: cycle 1 issue RAM read / select register; cycle 2 hpi_data_out loaded -> HOLD. Data valid 3 Clk after strobe at pins. DATA read post-increments addr_reg by 2; MAILBOX read returns tx_data and clears tx_full; ADDRESS returns addr_reg; STATUS = {13'b0, overrun, rx_valid, tx_full}.
- HOLD: wait until cs_n=1 or (r_n=1 and w_n=1) -> IDLE; one access per strobe assertion, no repeat.
- hpi_data_out holds last read value between reads.
- addr_reg is a byte address; bit0 ignored; increments wrap 16'hFFFE -> 0. Word index >= DEPTH: writes dropped, reads return 0.
- Mailboxes: mbx_tx_ready = ~tx_full (registered); load on valid & ready; hpi_int = tx_full. rx: ack clears rx_valid; host write and ack same cycle -> new write wins, rx_valid stays 1.
- Host DATA write and loc_we to same word same cycle: host wins. loc_rdata reflects RAM contents before a same-cycle write (read-first).

Decomposition:
- Package hpi_pkg: HPI_DATA/MAILBOX/ADDRESS/STATUS codes, status bit indices (ST_TXF=0, ST_RXV=1, ST_OVR=2), FSM enum {IDLE, WR, RD, RD2, HOLD}.
- Sub-module hpi_dpram: true dual-port 16-bit RAM, port A host, port B fabric, read-first, host priority on collision.

Test Plan:
- Write ADDRESS 16'h0100, DATA 16'hBEEF, 16'hCAFE; write ADDRESS 16'h0100, read DATA twice -> 16'hBEEF, 16'hCAFE; read ADDRESS -> 16'h0104.
- Fabric mbx_tx_data 16'h1234 with valid -> hpi_int=1, ready=0, STATUS=0x0001; host reads MAILBOX -> 16'h1234, hpi_int=0 next cycle, ready=1.
- Host writes MAILBOX 16'hAAAA then 16'h5555 without ack -> mbx_rx_data 16'h5555, STATUS=0x0006; STATUS write 0x0004 -> 0x0002; ack -> 0x0000.
- loc_we word 0x080 = 16'h00A5; host ADDRESS 16'h0100, DATA read -> 16'h00A5; ADDRESS 16'hFFFE DATA read -> 0, ADDRESS reads 16'h0000 (wrap).
- Hold cs_n/r_n low 20 cycles -> exactly one increment; both strobes low -> no state change.
- hpi_reset_n pulse mid-access -> addr_reg 0, mailboxes cleared, RAM data preserved; async Reset mid-read -> all outputs 0 immediately.
